reg_serializer: RTL and testbench

REG_SERIALIZER -- requirements
Module: reg_serializer

---
 rtl/reg_serializer.sv | 119 +++++++++++
 tb/tb_reg_serializer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_serializer.sv
// Register-range serializer: reads a wrapping address range and shifts each byte out.
// Define PAR_BIT_EN to append an even-parity bit after every byte.
module reg_serializer (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       dir,
    input  logic [2:0] first_addr,
    input  logic [2:0] last_addr,
    output logic [2:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       ser_out,
    output logic       ser_valid,
    input  logic       ser_ready,
    output logic       busy,
    output logic       done
);

`ifdef PAR_BIT_EN
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, PARITY, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DONE} state_t;
`endif

    state_t     state, state_nxt;
    logic       dir_q;
    logic [2:0] last_q;
    logic [2:0] cnt;
    logic [7:0] sreg;
    logic       accept;
    logic       byte_end;
    logic       last_byte;
`ifdef PAR_BIT_EN
    logic       par_q;
`endif

    assign accept    = ser_valid & ser_ready;
    assign last_byte = (rd_addr == last_q);
`ifdef PAR_BIT_EN
    assign byte_end  = (state == PARITY) & accept;
`else
    assign byte_end  = (state == SHIFT) & accept & (cnt == 3'd7);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
`ifdef PAR_BIT_EN
            SHIFT:   if (accept && cnt == 3'd7) state_nxt = PARITY;
            PARITY:  if (byte_end) state_nxt = last_byte ? DONE : LOAD;
`else
            SHIFT:   if (byte_end) state_nxt = last_byte ? DONE : LOAD;
`endif
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ser_valid = 1'b0;
        ser_out   = 1'b0;
        busy      = (state != IDLE);
        done      = (state == DONE);
        unique case (state)
            SHIFT: begin
                ser_valid = 1'b1;
                ser_out   = dir_q ? sreg[0] : sreg[7];
            end
`ifdef PAR_BIT_EN
            PARITY: begin
                ser_valid = 1'b1;
                ser_out   = par_q;
            end
`endif
            default: ;
        endcase
    end

    // Datapath: config latch, byte capture, shifting and address advance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir_q   <= 1'b0;
            last_q  <= 3'd0;
            rd_addr <= 3'd0;
            sreg    <= 8'd0;
            cnt     <= 3'd0;
`ifdef PAR_BIT_EN
            par_q   <= 1'b0;
`endif
        end else begin
            if (state == IDLE && start) begin
                dir_q   <= dir;
                last_q  <= last_addr;
                rd_addr <= first_addr;
            end
            if (state == LOAD) begin
                sreg <= rd_data;
                cnt  <= 3'd0;
`ifdef PAR_BIT_EN
                par_q <= ^rd_data;
`endif
            end
            if (state == SHIFT && accept) begin
                sreg <= dir_q ? {1'b0, sreg[7:1]} : {sreg[6:0], 1'b0};
                cnt  <= cnt + 3'd1;
            end
            if (byte_end && !last_byte)
                rd_addr <= rd_addr + 3'd1;
        end
    end

endmodule

// File: tb/tb_reg_serializer.sv
// Directed bench for reg_serializer: single bytes, wrapping range, stall, reset.
// Build with PAR_BIT_EN defined to also check the parity bit.
module tb_reg_serializer;

`ifdef PAR_BIT_EN
    localparam int NB = 9;
    localparam int PX = 1;
`else
    localparam int NB = 8;
    localparam int PX = 0;
`endif

    logic       clk = 1'b0;
    logic       reset, start, dir, ser_ready;
    logic [2:0] first_addr, last_addr, rd_addr;
    logic [7:0] rd_data;
    logic       ser_out, ser_valid, busy, done;
    logic [7:0] rf [8];

    int checks = 0;
    int failures = 0;

    logic [63:0] got;
    logic [7:0]  pars;
    logic [23:0] addrs;
    int          nbits;
    int          done_cyc;

    typedef struct {
        logic       d;
        logic [2:0] a;
        logic [7:0] data;
        logic [7:0] exp;
        logic       par;
    } vec_t;
    vec_t vt [7];

    reg_serializer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dir        (dir),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .ser_ready  (ser_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    assign rd_data = rf[rd_addr];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_xfer(input logic d, input logic [2:0] f,
                            input logic [2:0] l, input int stall_at,
                            input int stall_len, input logic hold);
        int   stalled = 0;
        int   c;
        logic frz = 1'b0;
        got = '0; pars = '0; addrs = '0; nbits = 0; done_cyc = -1;
        dir = d; first_addr = f; last_addr = l;
        start = 1'b1; ser_ready = 1'b1;
        tick;
        c = 1;
        start = hold;
        while (c < 300) begin
            if (done) begin
                done_cyc = c;
                break;
            end
            ser_ready = !(nbits == stall_at && stalled < stall_len);
            if (!ser_ready) begin
                if (stalled == 0) frz = ser_out;
                else chk("stall_hold", ser_out, frz);
                chk("stall_valid", ser_valid, 1);
                stalled++;
            end
            if (ser_valid && ser_ready) begin
                if (nbits % NB == 8) pars = {pars[6:0], ser_out};
                else begin
                    got = {got[62:0], ser_out};
                    if (nbits % NB == 0) addrs = {addrs[20:0], rd_addr};
                end
                nbits++;
            end
            tick;
            c++;
        end
        start = 1'b0;
        ser_ready = 1'b1;
        if (done_cyc < 0) begin
            checks++;
            failures++;
            $display("FAIL timeout: no done within 300 cycles");
        end
        tick;
        chk("done_one_cycle", done, 0);
        chk("idle_after", busy, 0);
    endtask

    initial begin
        int n;
        int bad_busy, bad_done;
        vt[0] = '{1'b0, 3'd2, 8'hA5, 8'hA5, 1'b0};
        vt[1] = '{1'b1, 3'd2, 8'hA5, 8'hA5, 1'b0};
        vt[2] = '{1'b1, 3'd2, 8'h01, 8'h80, 1'b1};
        vt[3] = '{1'b0, 3'd5, 8'h01, 8'h01, 1'b1};
        vt[4] = '{1'b0, 3'd3, 8'h07, 8'h07, 1'b1};
        vt[5] = '{1'b1, 3'd4, 8'h03, 8'hC0, 1'b0};
        vt[6] = '{1'b1, 3'd7, 8'hB1, 8'h8D, 1'b0};

        for (int i = 0; i < 8; i++) rf[i] = 8'h00;
        reset = 1'b0; start = 1'b0; dir = 1'b0; ser_ready = 1'b1;
        first_addr = 3'd0; last_addr = 3'd0;
        tick; tick;
        chk("rst_busy", busy, 0);
        chk("rst_valid", ser_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", rd_addr, 0);
        chk("rst_out", ser_out, 0);
        @(negedge clk);
        reset = 1'b1;
        tick;

        for (int i = 0; i < 7; i++) begin
            rf[vt[i].a] = vt[i].data;
            run_xfer(vt[i].d, vt[i].a, vt[i].a, -1, 0, 1'b0);
            chk("vec_stream", got[7:0], vt[i].exp);
            chk("vec_nbits", nbits, NB);
            chk("vec_done_cyc", done_cyc, 10 + PX);
            chk("vec_addr", addrs[2:0], vt[i].a);
`ifdef PAR_BIT_EN
            chk("vec_parity", pars[0], vt[i].par);
`endif
        end

        rf[6] = 8'h11; rf[7] = 8'h22; rf[0] = 8'h33; rf[1] = 8'h44;
        run_xfer(1'b0, 3'd6, 3'd1, -1, 0, 1'b0);
        chk("wrap_stream", got[31:0], 32'h11223344);
        chk("wrap_nbits", nbits, 4 * NB);
        chk("wrap_addrs", addrs[11:0], 12'hDC1);
        chk("wrap_done_cyc", done_cyc, 1 + 4 * (9 + PX));
`ifdef PAR_BIT_EN
        chk("wrap_parity", pars[3:0], 4'h0);
`endif

        rf[2] = 8'hA5;
        run_xfer(1'b0, 3'd2, 3'd2, 3, 5, 1'b1);
        chk("stall_stream", got[7:0], 8'hA5);
        chk("stall_nbits", nbits, NB);
        chk("stall_done_cyc", done_cyc, 15 + PX);

        rf[0] = 8'hF0; rf[1] = 8'h0F;
        dir = 1'b0; first_addr = 3'd0; last_addr = 3'd1;
        start = 1'b1; ser_ready = 1'b1;
        tick;
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 100 && n < NB + 4; i++) begin
            if (ser_valid) n++;
            tick;
        end
        chk("mid_reach", n, NB + 4);
        chk("mid_valid_pre", ser_valid, 1);
        reset = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_valid", ser_valid, 0);
        chk("mid_addr", rd_addr, 0);
        chk("mid_done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        bad_busy = 0; bad_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (busy) bad_busy++;
            if (done) bad_done++;
        end
        chk("post_rst_busy", bad_busy, 0);
        chk("post_rst_done", bad_done, 0);

        rf[3] = 8'h5A;
        run_xfer(1'b0, 3'd3, 3'd3, -1, 0, 1'b0);
        chk("restart_stream", got[7:0], 8'h5A);
        chk("restart_done_cyc", done_cyc, 10 + PX);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
